// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with registered 2*WIDTH result (HI:LO).
// Single-cycle ops: ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
// Iterative ops: signed MUL (Booth radix-2) and signed DIV (restoring).
//
// Ports:
//   clock        rising-edge clock
//   clear        synchronous active-high reset
//   start        one-cycle request, sampled only in IDLE
//   select[4:0]  opcode, sampled with start
//   A, B         operands, sampled with start
//   busy         high from the cycle after an accepted iterative start until done
//   done         one-cycle pulse; Z is valid from this cycle
//   Z            registered result, HI = Z[2W-1:W], LO = Z[W-1:0]
//   div_by_zero  set with done for DIV with B==0; cleared by the next accepted start
//
// Handshake: start is accepted only when the FSM is in IDLE; a start seen while
// busy or in DONE is dropped (no queueing). Operands and opcode are captured at
// the accepting edge, so they may change freely afterwards. Every accepted start
// produces exactly one done pulse unless clear intervenes.
// The FSM state is kept in the named signal 'state' for debug visibility.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         select,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Z,
    output logic               div_by_zero
);
    localparam int CW = SHW + 1;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_NEG  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b01111;

    typedef enum logic [2:0] {IDLE, MUL_ITER, DIV_ITER, FIXUP, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    // acc_hi is one bit wider than an operand so Booth add/sub of the
    // most-negative multiplicand cannot overflow.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] m_reg;
    logic             qm1;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   amt_neg;
    logic [WIDTH-1:0] quick_lo;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_hi;
    logic [WIDTH-1:0] booth_lo;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic [WIDTH:0]   div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    // Single-cycle datapath.
    always_comb begin
        amt      = B[SHW-1:0];
        // Rotate-left by n equals rotate-right by (WIDTH - n) mod WIDTH.
        amt_neg  = -amt;
        quick_lo = '0;
        case (select)
            OP_ADD:  quick_lo = A + B;
            OP_SUB:  quick_lo = A - B;
            OP_AND:  quick_lo = A & B;
            OP_OR:   quick_lo = A | B;
            OP_SHR:  quick_lo = A >> amt;
            OP_SHRA: quick_lo = $signed(A) >>> amt;
            OP_SHL:  quick_lo = A << amt;
            OP_ROR:  quick_lo = WIDTH'({A, A} >> amt);
            OP_ROL:  quick_lo = WIDTH'({A, A} >> amt_neg);
            OP_NEG:  quick_lo = -A;
            OP_NOT:  quick_lo = ~A;
            default: quick_lo = '0;
        endcase
        abs_a = A[WIDTH-1] ? -A : A;
        abs_b = B[WIDTH-1] ? -B : B;
    end

    // One Booth radix-2 step: add/sub multiplicand by {Q0, Q-1}, then
    // arithmetic shift of {acc_hi, acc_lo, qm1} right by one.
    always_comb begin
        m_ext = {m_reg[WIDTH-1], m_reg};
        case ({acc_lo[0], qm1})
            2'b01:   booth_sum = acc_hi + m_ext;
            2'b10:   booth_sum = acc_hi - m_ext;
            default: booth_sum = acc_hi;
        endcase
        booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo = {booth_sum[0], acc_lo[WIDTH-1:1]};
    end

    // One restoring-division step on magnitudes: acc_hi holds the partial
    // remainder, acc_lo shifts the dividend out and the quotient in.
    always_comb begin
        rem_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, m_reg};
        if (rem_trial[WIDTH]) begin
            div_hi = rem_shift;
            div_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end else begin
            div_hi = rem_trial;
            div_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end
        // Quotient truncates toward zero; remainder takes the dividend's sign.
        fix_q = neg_q ? -acc_lo : acc_lo;
        fix_r = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            count       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            m_reg       <= '0;
            qm1         <= 1'b0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Z           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (select == OP_MUL) begin
                            acc_hi <= '0;
                            acc_lo <= A;
                            m_reg  <= B;
                            qm1    <= 1'b0;
                            is_div <= 1'b0;
                            count  <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= MUL_ITER;
                        end else if (select == OP_DIV && B != '0) begin
                            acc_hi <= '0;
                            acc_lo <= abs_a;
                            m_reg  <= abs_b;
                            qm1    <= 1'b0;
                            neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_r  <= A[WIDTH-1];
                            is_div <= 1'b1;
                            count  <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= DIV_ITER;
                        end else if (select == OP_DIV) begin
                            Z           <= {A, {WIDTH{1'b1}}};
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            Z     <= {{WIDTH{1'b0}}, quick_lo};
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                MUL_ITER: begin
                    acc_hi <= booth_hi;
                    acc_lo <= booth_lo;
                    qm1    <= acc_lo[0];
                    count  <= count - CW'(1);
                    if (count == CW'(1)) state <= FIXUP;
                end
                DIV_ITER: begin
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) state <= FIXUP;
                end
                FIXUP: begin
                    Z     <= is_div ? {fix_r, fix_q} : {acc_hi[WIDTH-1:0], acc_lo};
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: a WIDTH=32 and a WIDTH=16 instance, each with an
// expected-result queue filled by the driver and drained by a monitor on done.
`timescale 1ns/1ps
module tb_seq_alu;
    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic clear;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        start_32, busy_32, done_32, dbz_32;
    logic [4:0]  select_32;
    logic [31:0] a_32, b_32;
    logic [63:0] z_32;

    logic        start_16, busy_16, done_16, dbz_16;
    logic [4:0]  select_16;
    logic [15:0] a_16, b_16;
    logic [31:0] z_16;

    seq_alu #(.WIDTH(32)) dut32 (
        .clock(clock), .clear(clear), .start(start_32), .select(select_32),
        .A(a_32), .B(b_32), .busy(busy_32), .done(done_32), .Z(z_32),
        .div_by_zero(dbz_32)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clock(clock), .clear(clear), .start(start_16), .select(select_16),
        .A(a_16), .B(b_16), .busy(busy_16), .done(done_16), .Z(z_16),
        .div_by_zero(dbz_16)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {busy_cycles[15:0], done_cycle[31:0], dbz, z[63:0]}
    logic [112:0] exp_q[$];
    logic [112:0] exp16_q[$];
    int errors = 0;
    int checks = 0;
    logic [63:0] last_z32 = '0;
    int busy_cnt32 = 0;
    int busy_cnt16 = 0;
    logic [4:0] op_list [0:18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [112:0] pack(input logic [63:0] z, input logic dbz, input int cyc_e, input int busy_e);
        return {16'(busy_e), 32'(cyc_e), dbz, z};
    endfunction

    // Reference model: plain arithmetic on longint values of width w.
    function automatic logic [64:0] model(input int w, input logic [4:0] sel,
                                          input logic [31:0] a_in, input logic [31:0] b_in);
        longint a, b, sa, sb, x, mw;
        logic [63:0] z;
        logic dbz;
        int amt;
        mw  = (longint'(1) << w) - 1;
        a   = longint'(a_in);
        b   = longint'(b_in);
        sa  = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
        sb  = (b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
        amt = int'(b % longint'(w));
        dbz = 1'b0;
        z   = '0;
        case (sel)
            5'd0:  z = 64'((a + b) & mw);
            5'd1:  z = 64'((a - b) & mw);
            5'd2:  z = 64'(a & b);
            5'd3:  z = 64'(a | b);
            5'd4:  z = 64'(a >> amt);
            5'd5:  z = 64'((sa >>> amt) & mw);
            5'd6:  z = 64'((a << amt) & mw);
            5'd7: begin
                x = a;
                repeat (amt) x = (x >> 1) | ((x & 1) << (w - 1));
                z = 64'(x);
            end
            5'd8: begin
                x = a;
                repeat (amt) x = ((x << 1) & mw) | (x >> (w - 1));
                z = 64'(x);
            end
            5'd9: begin
                z = 64'(sa * sb);
                if (w < 32) z = z & ((64'd1 << (2 * w)) - 64'd1);
            end
            5'd10: begin
                if (b == 0) begin
                    dbz = 1'b1;
                    z   = 64'((a << w) | mw);
                end else begin
                    z = 64'(((sa % sb) & mw) << w) | 64'((sa / sb) & mw);
                end
            end
            5'd14: z = 64'((-a) & mw);
            5'd15: z = 64'((~a) & mw);
            default: z = '0;
        endcase
        return {dbz, z};
    endfunction

    function automatic int lat(input logic [4:0] sel, input logic [31:0] b, input int w);
        if (sel == 5'd9 || (sel == 5'd10 && b != 0)) return w + 1;
        return 0;
    endfunction

    function automatic logic [31:0] rnd(input int w);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return mask;
            2: return 32'd1 << (w - 1);
            3: return mask >> 1;
            4: return 32'($urandom_range(0, 9));
            default: return $urandom & mask;
        endcase
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clock) begin
        logic [112:0] e;
        if (clear) begin
            busy_cnt32 = 0;
        end else begin
            if (busy_32) busy_cnt32++;
            if (done_32) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done32: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("z32", z_32, e[63:0]);
                    check("dbz32", 64'(dbz_32), 64'(e[64]));
                    check("done_cycle32", 64'(cyc), 64'(e[96:65]));
                    check("busy_cycles32", 64'(busy_cnt32), 64'(e[112:97]));
                    last_z32 = e[63:0];
                end
                busy_cnt32 = 0;
            end
        end
    end

    always @(negedge clock) begin
        logic [112:0] e;
        if (clear) begin
            busy_cnt16 = 0;
        end else begin
            if (busy_16) busy_cnt16++;
            if (done_16) begin
                if (exp16_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done16: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    e = exp16_q.pop_front();
                    check("z16", 64'(z_16), e[63:0]);
                    check("dbz16", 64'(dbz_16), 64'(e[64]));
                    check("done_cycle16", 64'(cyc), 64'(e[96:65]));
                    check("busy_cycles16", 64'(busy_cnt16), 64'(e[112:97]));
                end
                busy_cnt16 = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue32(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b, input bit push);
        logic [64:0] m;
        int l;
        m = model(32, sel, a, b);
        l = lat(sel, b, 32);
        if (push) exp_q.push_back(pack(m[63:0], m[64], cyc + 1 + l, l));
        start_32 = 1'b1; select_32 = sel; a_32 = a; b_32 = b;
        @(posedge clock); #1;
        start_32 = 1'b0; select_32 = 5'($urandom); a_32 = $urandom; b_32 = $urandom;
    endtask

    task automatic issue16(input logic [4:0] sel, input logic [15:0] a, input logic [15:0] b);
        logic [64:0] m;
        int l;
        m = model(16, sel, {16'd0, a}, {16'd0, b});
        l = lat(sel, {16'd0, b}, 16);
        exp16_q.push_back(pack(m[63:0], m[64], cyc + 1 + l, l));
        start_16 = 1'b1; select_16 = sel; a_16 = a; b_16 = b;
        @(posedge clock); #1;
        start_16 = 1'b0; select_16 = 5'($urandom); a_16 = 16'($urandom); b_16 = 16'($urandom);
    endtask

    task automatic wait_idle32();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout32: got %0d results outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (exp16_q.size() != 0 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (exp16_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout16: got %0d results outstanding expected 0", exp16_q.size());
            exp16_q.delete();
        end
    endtask

    task automatic run32(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        issue32(sel, a, b, 1'b1);
        wait_idle32();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: got still running at %0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        op_list = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                    5'd10, 5'd14, 5'd15, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd31};
        clear = 1'b1;
        start_32 = 1'b0; select_32 = '0; a_32 = '0; b_32 = '0;
        start_16 = 1'b0; select_16 = '0; a_16 = '0; b_16 = '0;
        repeat (3) @(posedge clock);
        #1;
        clear = 1'b0;

        check("reset_busy32", 64'(busy_32), 64'd0);
        check("reset_done32", 64'(done_32), 64'd0);
        check("reset_z32", z_32, 64'd0);
        check("reset_dbz32", 64'(dbz_32), 64'd0);
        check("reset_busy16", 64'(busy_16), 64'd0);
        check("reset_z16", 64'(z_16), 64'd0);

        // Directed cases, including the boundary values.
        run32(5'd0,  32'h7FFF_FFFF, 32'd1);
        run32(5'd1,  32'd5,         32'd7);
        run32(5'd7,  32'h0000_0001, 32'h21);
        run32(5'd8,  32'h8000_0001, 32'd4);
        run32(5'd5,  32'h8000_0000, 32'd31);
        run32(5'd6,  32'h1234_5678, 32'h20);
        run32(5'd7,  32'hDEAD_BEEF, 32'h0);
        run32(5'd8,  32'hDEAD_BEEF, 32'h0);
        run32(5'd4,  32'hF000_0000, 32'd28);
        run32(5'd9,  32'hFFFF_FFFD, 32'd7);
        run32(5'd9,  32'h8000_0000, 32'h8000_0000);
        run32(5'd9,  32'h8000_0000, 32'hFFFF_FFFF);
        run32(5'd10, 32'hFFFF_FFF9, 32'd2);
        run32(5'd10, 32'h8000_0000, 32'hFFFF_FFFF);
        run32(5'd10, 32'd100,       32'hFFFF_FFF9);
        run32(5'd14, 32'd1,         32'd0);
        run32(5'd15, 32'h0F0F_0F0F, 32'd0);
        run32(5'd31, 32'h1234_5678, 32'h1);
        run32(5'd10, 32'd9,         32'd0);

        // Start during busy is dropped; Z holds and div_by_zero has cleared.
        issue32(5'd9, 32'd123456, 32'hFFFF_FF00, 1'b1);
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("hold_z_while_busy", z_32, last_z32);
        check("busy_during_mul", 64'(busy_32), 64'd1);
        check("dbz_cleared_on_start", 64'(dbz_32), 64'd0);
        issue32(5'd0, 32'd1, 32'd1, 1'b0);
        wait_idle32();

        // Start during the DONE cycle is dropped.
        issue32(5'd0, 32'd40, 32'd2, 1'b1);
        issue32(5'd1, 32'd9, 32'd3, 1'b0);
        wait_idle32();

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            logic [4:0] sel;
            sel = op_list[$urandom_range(0, 18)];
            run32(sel, rnd(32), rnd(32));
        end
        run32(5'd0, 32'h0000_1111, 32'h0000_2222);

        // clear in the middle of a DIV: no done pulse, outputs at reset values.
        issue32(5'd10, 32'hFFFF_0000, 32'd3, 1'b0);
        repeat (8) begin
            @(posedge clock); #1;
        end
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        check("clear_busy32", 64'(busy_32), 64'd0);
        check("clear_done32", 64'(done_32), 64'd0);
        check("clear_z32", z_32, 64'd0);
        check("clear_dbz32", 64'(dbz_32), 64'd0);
        repeat (40) begin
            @(posedge clock); #1;
        end

        // clear and start in the same cycle: clear wins.
        clear = 1'b1;
        start_32 = 1'b1; select_32 = 5'd0; a_32 = 32'd1; b_32 = 32'd1;
        @(posedge clock); #1;
        clear = 1'b0;
        start_32 = 1'b0;
        check("clear_start_done", 64'(done_32), 64'd0);
        check("clear_start_z", z_32, 64'd0);
        @(posedge clock); #1;
        check("clear_start_done_later", 64'(done_32), 64'd0);

        // WIDTH=16 instance.
        issue16(5'd9, 16'h7FFF, 16'h7FFF);
        wait_idle16();
        issue16(5'd10, 16'h8000, 16'hFFFF);
        wait_idle16();
        issue16(5'd8, 16'h8001, 16'd20);
        wait_idle16();
        for (int i = 0; i < 25; i++) begin
            logic [4:0] sel;
            sel = op_list[$urandom_range(0, 18)];
            issue16(sel, 16'(rnd(16)), 16'(rnd(16)));
            wait_idle16();
        end

        repeat (4) begin
            @(posedge clock); #1;
        end
        wait_idle32();
        wait_idle16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
